// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate L1 data cache.
// One request in flight at a time from the load/store pipeline. Load misses
// refill a whole line in a burst; stores always go to memory and update the
// cached line only on a hit.
module dcache_wt #(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] dm_req_addr,
   input  logic [63:0] dm_req_wdata,
   input  logic [7:0]  dm_req_wmask,
   input  logic        dm_req_wen,
   input  logic        dm_req_valid,
   output logic        dm_req_ready,
   output logic [63:0] dm_resp_rdata,
   output logic        dm_resp_valid,
   input  logic        flush,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wmask,
   output logic        mem_req_wen,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   input  logic [63:0] mem_resp_rdata,
   input  logic        mem_resp_valid
);

   localparam int WB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TB = 64 - 3 - WB - IB;
   localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOOKUP     = 3'd1,
      S_REFILL_REQ = 3'd2,
      S_REFILL     = 3'd3,
      S_WRITE_REQ  = 3'd4,
      S_WRITE_WAIT = 3'd5,
      S_RESP       = 3'd6
   } state_t;

   state_t          state_q;
   logic [63:3]     addr_q;
   logic [63:0]     wdata_q;
   logic [7:0]      wmask_q;
   logic            wen_q;
   logic [WB-1:0]   beat_q;
   logic [63:0]     crit_q;
   logic [LINES-1:0] valid_q;
   logic [TB-1:0]   tag_q  [LINES];
   logic [63:0]     data_q [LINES][LINE_WORDS];

   logic [WB-1:0]   word_s;
   logic [IB-1:0]   idx_s;
   logic [TB-1:0]   tag_s;
   logic            hit_s;
   logic            unused_s;

   // Byte-lane merge of store data into an existing word.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  mask);
      logic [63:0] res;
      res = old_v;
      for (int b = 0; b < 8; b++) begin
         if (mask[b]) begin
            res[b*8 +: 8] = new_v[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_v[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // The byte offset never matters: responses and writes are doubleword wide.
   assign unused_s = ^dm_req_addr[2:0];

   assign word_s = addr_q[3 +: WB];
   assign idx_s  = addr_q[3 + WB +: IB];
   assign tag_s  = addr_q[63 -: TB];
   assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

   // Control FSM: request capture, valid bits, beat counter, critical word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         wdata_q <= 64'h0;
         wmask_q <= 8'h00;
         wen_q   <= 1'b0;
         crit_q  <= 64'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (flush) begin
                  valid_q <= '0;
               end else if (dm_req_valid) begin
                  addr_q  <= dm_req_addr[63:3];
                  wdata_q <= dm_req_wdata;
                  wmask_q <= dm_req_wmask;
                  wen_q   <= dm_req_wen;
                  state_q <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (wen_q) begin
                  state_q <= S_WRITE_REQ;
               end else if (hit_s) begin
                  state_q <= S_IDLE;
               end else begin
                  // Invalidate before refilling so a partial line is never hit.
                  valid_q[idx_s] <= 1'b0;
                  state_q        <= S_REFILL_REQ;
               end
            end
            S_REFILL_REQ: begin
               if (mem_req_ready) begin
                  beat_q  <= '0;
                  state_q <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (mem_resp_valid) begin
                  beat_q <= beat_q + WB'(1);
                  if (beat_q == word_s) begin
                     crit_q <= mem_resp_rdata;
                  end
                  if (beat_q == LAST_BEAT) begin
                     valid_q[idx_s] <= 1'b1;
                     state_q        <= S_RESP;
                  end
               end
            end
            S_WRITE_REQ: begin
               if (mem_req_ready) begin
                  state_q <= S_WRITE_WAIT;
               end
            end
            S_WRITE_WAIT: begin
               if (mem_resp_valid) begin
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Tag and data arrays: store-hit merge and refill beats (not reset).
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_LOOKUP && wen_q && hit_s) begin
            data_q[idx_s][word_s] <= merge_bytes(data_q[idx_s][word_s], wdata_q, wmask_q);
         end
         if (state_q == S_REFILL && mem_resp_valid) begin
            data_q[idx_s][beat_q] <= mem_resp_rdata;
            if (beat_q == LAST_BEAT) begin
               tag_q[idx_s] <= tag_s;
            end
         end
      end
   end

   // Pipeline response: load hits answer from LOOKUP, everything else from RESP.
   always_comb begin
      dm_resp_valid = 1'b0;
      dm_resp_rdata = 64'h0;
      if (state_q == S_LOOKUP && !wen_q && hit_s) begin
         dm_resp_valid = 1'b1;
         dm_resp_rdata = data_q[idx_s][word_s];
      end else if (state_q == S_RESP) begin
         dm_resp_valid = 1'b1;
         dm_resp_rdata = wen_q ? 64'h0 : crit_q;
      end else begin
         dm_resp_valid = 1'b0;
         dm_resp_rdata = 64'h0;
      end
   end

   assign dm_req_ready  = (state_q == S_IDLE) && !flush;

   // Bus request fields come only from registers, so they hold during a stall.
   assign mem_req_valid = (state_q == S_REFILL_REQ) || (state_q == S_WRITE_REQ);
   assign mem_req_wen   = (state_q == S_WRITE_REQ);
   assign mem_req_addr  = (state_q == S_WRITE_REQ) ? {addr_q, 3'b000}
                                                   : {addr_q[63:3+WB], {(WB+3){1'b0}}};
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: a vector table of single requests with
// hand-computed results, plus sequences for bus stall, flush and reset.
module tb_dcache_wt;

   logic        clk;
   logic        rst;
   logic [63:0] dm_req_addr;
   logic [63:0] dm_req_wdata;
   logic [7:0]  dm_req_wmask;
   logic        dm_req_wen;
   logic        dm_req_valid;
   logic        dm_req_ready;
   logic [63:0] dm_resp_rdata;
   logic        dm_resp_valid;
   logic        flush;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_req_wen;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_resp_rdata;
   logic        mem_resp_valid;

   dcache_wt #(.LINES(64), .LINE_WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
      .dm_req_wmask(dm_req_wmask), .dm_req_wen(dm_req_wen),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
      .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
      .flush(flush),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_wmask(mem_req_wmask), .mem_req_wen(mem_req_wen),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_resp_rdata(mem_resp_rdata), .mem_resp_valid(mem_resp_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // bus model bookkeeping
   logic        hold_ready = 1'b0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [63:0] last_raddr = 64'h0;
   logic [63:0] last_waddr = 64'h0;
   logic [63:0] last_wdata = 64'h0;
   logic [7:0]  last_wmask = 8'h00;

   // Backing memory contents: word at 0x1000 is 0xA0, counting up per doubleword.
   function automatic logic [63:0] mem_word(input logic [63:0] a);
      return 64'hA0 + ((a - 64'h1000) >> 3);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory bus responder: accepts one request, then bursts 4 beats or acks a write.
   initial begin : bus
      logic        wen_l;
      logic [63:0] addr_l;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 64'h0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         mem_req_ready  = 1'b0;
         if (mem_req_valid && !hold_ready && !rst) begin
            mem_req_ready = 1'b1;
            wen_l  = mem_req_wen;
            addr_l = mem_req_addr;
            if (wen_l) begin
               n_wr++;
               last_waddr = mem_req_addr;
               last_wdata = mem_req_wdata;
               last_wmask = mem_req_wmask;
            end else begin
               n_rd++;
               last_raddr = mem_req_addr;
            end
            @(negedge clk);
            mem_req_ready = 1'b0;
            if (wen_l) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = 64'h0;
            end else begin
               for (int k = 0; k < 4; k++) begin
                  mem_resp_rdata = mem_word(addr_l + 64'(k * 8));
                  mem_resp_valid = 1'b1;
                  if (k != 3) @(negedge clk);
               end
            end
         end
      end
   end

   // Present one request and return once it has been accepted.
   task automatic send(input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!dm_req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 100) begin
         errors++;
         $display("FAIL accept_timeout: ready never seen for addr %h", addr);
      end
      dm_req_wen   = wen;
      dm_req_addr  = addr;
      dm_req_wdata = wdata;
      dm_req_wmask = wmask;
      dm_req_valid = 1'b1;
      @(posedge clk);
      #1;
      dm_req_valid = 1'b0;
   endtask

   // Wait for the response; lat counts falling edges after the accept edge.
   task automatic wait_resp(output logic [63:0] rdata, output int lat);
      lat = 0;
      rdata = 64'h0;
      do begin
         @(negedge clk);
         lat++;
      end while (!dm_resp_valid && lat < 100);
      checks++;
      if (!dm_resp_valid) begin
         errors++;
         $display("FAIL resp_timeout: no response within %0d cycles", lat);
      end
      rdata = dm_resp_rdata;
   endtask

   typedef struct {
      logic        wen;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic [63:0] exp_rdata;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
      logic [63:0] exp_maddr;
   } vec_t;

   vec_t vecs [12];

   initial begin : main
      logic [63:0] rd;
      int lat, rd0, wr0;

      //           wen   addr         wdata                   mask   rdata                 lat rd wr maddr
      vecs[0]  = '{1'b0, 64'h1000, 64'h0,                  8'h00, 64'hA0,               7, 1, 0, 64'h1000};
      vecs[1]  = '{1'b0, 64'h1018, 64'h0,                  8'h00, 64'hA3,               1, 0, 0, 64'h0};
      vecs[2]  = '{1'b1, 64'h1008, 64'h5555555555555555,   8'h01, 64'h0,                4, 0, 1, 64'h1008};
      vecs[3]  = '{1'b0, 64'h100D, 64'h0,                  8'h00, 64'h55,               1, 0, 0, 64'h0};
      vecs[4]  = '{1'b0, 64'h1810, 64'h0,                  8'h00, 64'h1A2,              7, 1, 0, 64'h1800};
      vecs[5]  = '{1'b0, 64'h1000, 64'h0,                  8'h00, 64'hA0,               7, 1, 0, 64'h1000};
      vecs[6]  = '{1'b1, 64'h2000, 64'h1122334455667788,   8'hFF, 64'h0,                4, 0, 1, 64'h2000};
      vecs[7]  = '{1'b0, 64'h2000, 64'h0,                  8'h00, 64'h2A0,              7, 1, 0, 64'h2000};
      vecs[8]  = '{1'b0, 64'h2010, 64'h0,                  8'h00, 64'h2A2,              1, 0, 0, 64'h0};
      vecs[9]  = '{1'b1, 64'h2010, 64'hCAFEF00D12345678,   8'hF0, 64'h0,                4, 0, 1, 64'h2010};
      vecs[10] = '{1'b0, 64'h2010, 64'h0,                  8'h00, 64'hCAFEF00D000002A2, 1, 0, 0, 64'h0};
      vecs[11] = '{1'b0, 64'h2018, 64'h0,                  8'h00, 64'h2A3,              1, 0, 0, 64'h0};

      rst = 1'b1;
      flush = 1'b0;
      dm_req_valid = 1'b0;
      dm_req_wen = 1'b0;
      dm_req_addr = 64'h0;
      dm_req_wdata = 64'h0;
      dm_req_wmask = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_ready", 64'(dm_req_ready), 64'h1);
      chk("reset_resp_valid", 64'(dm_resp_valid), 64'h0);
      chk("reset_mem_valid", 64'(mem_req_valid), 64'h0);

      // Table of single requests
      for (int i = 0; i < 12; i++) begin
         rd0 = n_rd;
         wr0 = n_wr;
         send(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
         wait_resp(rd, lat);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         chk($sformatf("v%0d_bus_reads", i), 64'(n_rd - rd0), 64'(vecs[i].exp_rd));
         chk($sformatf("v%0d_bus_writes", i), 64'(n_wr - wr0), 64'(vecs[i].exp_wr));
         if (vecs[i].exp_rd != 0) begin
            chk($sformatf("v%0d_refill_addr", i), last_raddr, vecs[i].exp_maddr);
         end
         if (vecs[i].exp_wr != 0) begin
            chk($sformatf("v%0d_write_addr", i), last_waddr, vecs[i].exp_maddr);
            chk($sformatf("v%0d_write_mask", i), 64'(last_wmask), 64'(vecs[i].wmask));
            chk($sformatf("v%0d_write_data", i), last_wdata, vecs[i].wdata);
         end
      end

      // Bus stall during refill request: request fields hold, no response
      @(posedge clk);
      hold_ready = 1'b1;
      send(1'b0, 64'h1000, 64'h0, 8'h00);
      @(negedge clk);
      chk("stall_lookup_no_resp", 64'(dm_resp_valid), 64'h0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_mem_valid", c), 64'(mem_req_valid), 64'h1);
         chk($sformatf("stall%0d_mem_addr", c), mem_req_addr, 64'h1000);
         chk($sformatf("stall%0d_mem_wen", c), 64'(mem_req_wen), 64'h0);
         chk($sformatf("stall%0d_no_resp", c), 64'(dm_resp_valid), 64'h0);
         chk($sformatf("stall%0d_ready_low", c), 64'(dm_req_ready), 64'h0);
      end
      @(posedge clk);
      hold_ready = 1'b0;
      wait_resp(rd, lat);
      chk("stall_rdata", rd, 64'hA0);

      // Flush in IDLE drops the line that was just refilled
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_ready_low", 64'(dm_req_ready), 64'h0);
      @(negedge clk);
      flush = 1'b0;
      rd0 = n_rd;
      send(1'b0, 64'h1000, 64'h0, 8'h00);
      wait_resp(rd, lat);
      chk("flush_reload_rdata", rd, 64'hA0);
      chk("flush_reload_latency", 64'(lat), 64'd7);
      chk("flush_reload_reads", 64'(n_rd - rd0), 64'h1);

      // Reset in the middle of a refill request abandons it
      @(posedge clk);
      hold_ready = 1'b1;
      send(1'b0, 64'h3000, 64'h0, 8'h00);
      repeat (2) @(negedge clk);
      chk("midreset_mem_valid_before", 64'(mem_req_valid), 64'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_mem_valid", 64'(mem_req_valid), 64'h0);
      chk("midreset_resp_valid", 64'(dm_resp_valid), 64'h0);
      rst = 1'b0;
      #1;
      chk("midreset_ready", 64'(dm_req_ready), 64'h1);
      @(posedge clk);
      hold_ready = 1'b0;
      rd0 = n_rd;
      send(1'b0, 64'h2010, 64'h0, 8'h00);
      wait_resp(rd, lat);
      chk("postreset_rdata", rd, 64'h2A2);
      chk("postreset_latency", 64'(lat), 64'd7);
      chk("postreset_reads", 64'(n_rd - rd0), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate L1 data cache sitting between the load/store pipeline's D-mem request port and the external memory bus. It accepts one request at a time from the load/store pipeline. Each request returns exactly one in-order response, including stores. Load misses refill a whole line over a burst read; stores are always forwarded to memory and update the line only on a hit.

## Interface
- LINES, 64: number of lines; power of two.
- LINE_WORDS, 4: 64-bit words per line; power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- dm_req_addr  in  64  byte address; bits [2:0] ignored.
- dm_req_wdata  in  64  store data, already lane-replicated.
- dm_req_wmask  in  8  store byte enables.
- dm_req_wen  in  1  1 = store, 0 = load.
- dm_req_valid  in  1  request valid.
- dm_req_ready  out  1  request accepted when valid & ready.
- dm_resp_rdata  out  64  aligned doubleword for loads; 0 for stores.
- dm_resp_valid  out  1  one-cycle pulse per request; no backpressure.
- flush  in  1  invalidate all lines.
- mem_req_addr  out  64  line-aligned for refill, doubleword-aligned for writes.
- mem_req_wdata  out  64  write data.
- mem_req_wmask  out  8  write byte enables.
- mem_req_wen  out  1  1 = single-beat write, 0 = burst read of LINE_WORDS beats.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus request accepted.
- mem_resp_rdata  in  64  read beat data.
- mem_resp_valid  in  1  read beat, or write acknowledge.

## Operation
- Address split: offset [2:0]; word W = next log2(LINE_WORDS) bits; index I = next log2(LINES) bits; tag = remaining upper bits.
- Per-line state: valid bit, tag, LINE_WORDS data words. Arrays are flops or LUT-RAM with combinational read.
- States:
  - IDLE: dm_req_ready = !flush. On accept, register the request and go to LOOKUP.
  - LOOKUP: hit = valid[I] && tag match.
    - Load hit: dm_resp_valid = 1, rdata = data[I][W]; go to IDLE.
    - Load miss: clear valid[I]; go to REFILL_REQ.
    - Store: on hit, merge wdata into data[I][W] under wmask. Go to WRITE_REQ in all cases.
  - REFILL_REQ: mem_req_valid = 1, wen = 0, addr = line base. When mem_req_ready, go to REFILL; beat counter = 0.
  - REFILL: each mem_resp_valid writes data[I][counter] and increments the counter. On the beat where counter == W, capture the critical word. After the last beat, set tag[I] and valid[I], then go to RESP.
  - WRITE_REQ: mem_req_valid = 1, wen = 1, with the registered addr, wdata and wmask. When mem_req_ready, go to WRITE_WAIT.
  - WRITE_WAIT: on mem_resp_valid, go to RESP.
  - RESP: dm_resp_valid = 1; rdata = captured word for loads, 0 for stores; go to IDLE.
- flush is acted on only in IDLE, where it clears all valid bits in one cycle. In any other state, flush is ignored and the caller holds it until IDLE.
- A store miss never allocates.
- Stale data is never returned: valid[I] is cleared before a refill begins.
- The bus delivers refill beats in order, word 0 first.

## Timing
- Reset values: state IDLE, all valid bits 0, dm_resp_valid 0, mem_req_valid 0, dm_req_ready 1 (assuming flush = 0), beat counter 0. Tag and data arrays are not reset.
- Reset mid-refill or mid-write: return to IDLE and drop the transaction. The memory bus shares rst.
- Load hit: accepted at edge T; dm_resp_valid is high in the cycle after T. Peak rate is one request every 2 cycles.
- Load miss: mem_req_valid rises in the cycle after LOOKUP. dm_resp_valid comes 1 cycle after the last beat.
- Store: mem_req_valid rises in the cycle after LOOKUP. dm_resp_valid comes 1 cycle after the write acknowledge.
- mem_req_* outputs are stable while mem_req_valid && !mem_req_ready.
- dm_req_ready is 0 in every non-IDLE state.
- Beat counter width is log2(LINE_WORDS); it wraps to 0 on the last beat.

## Test plan
- Reset, then load 0x1000. Expect a burst read at 0x1000; beats 0xA0..0xA3 fill the line; response rdata 0xA0.
- Load 0x1018 next. Expect no bus traffic; 1-cycle response with rdata 0xA3.
- Store to 0x1008 with wdata 0x55 replicated and wmask 0x01. Expect a bus write at 0x1008 with mask 0x01; response after the acknowledge. A following load of 0x1008 hits and returns 0xA1 with byte 0 replaced by 0x55.
- Store miss to 0x2000, then load 0x2000. The store produces no refill; the load then misses and refills.
- Conflict: load 0x1000 + LINES*LINE_WORDS*8 evicts the line. A reload of 0x1000 misses again.
- Hold mem_req_ready low for 5 cycles during REFILL_REQ. mem_req_addr stays stable and there is no response. Then assert flush in IDLE; the next load of 0x1000 misses.
